// File: rtl/arb_pkg.sv
// Shared definitions for the two-input packet arbiter.
//   state_t : arbiter FSM states (IDLE, GRANT0, GRANT1), 2-bit encoding
//   DATA_W  : default stream data width
package arb_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

endpackage

// File: rtl/out_reg_slice.sv
// One-entry valid/ready output register carrying {last, data}.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : capture load_data/load_last this edge
//   load_data, load_last  : payload presented by the arbiter
//   accept_ok             : register can take a beat this cycle
//   out_valid/data/last   : registered output stream
//   out_ready             : downstream accepts the current beat
module out_reg_slice
    import arb_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         accept_ok,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);

    logic         valid_q;
    logic [W:0]   payload_q;

    // Empty, or the held beat leaves this cycle: either way a new beat fits.
    assign accept_ok = !valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load) begin
            valid_q   <= 1'b1;
            payload_q <= {load_last, load_data};
        end else if (out_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = payload_q[W-1:0];
    assign out_last  = payload_q[W];

endmodule

// File: rtl/stream_arb2_sel.sv
// Two-input packet-aware round-robin arbiter feeding a 2:1 mux.
// Whole packets are granted one at a time; under contention grants
// alternate between inputs per packet.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in0_valid/data/last/ready     : input stream 0
//   in1_valid/data/last/ready     : input stream 1
//   out_valid/data/last           : registered output stream
//   out_ready                     : downstream backpressure
//   sel                           : current / most recent grant index
//   busy                          : a packet grant is active
module stream_arb2_sel
    import arb_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_valid,
    input  logic [W-1:0] in0_data,
    input  logic         in0_last,
    output logic         in0_ready,
    input  logic         in1_valid,
    input  logic [W-1:0] in1_data,
    input  logic         in1_last,
    output logic         in1_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         sel,
    output logic         busy
);

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic         sel_q, sel_d;
    logic         accept_ok;
    logic         xfer0, xfer1;
    logic         load;
    logic [W-1:0] load_data;
    logic         load_last;

    // Ready depends only on grant state and output occupancy, never on valid.
    assign in0_ready = (state_q == GRANT0) && accept_ok;
    assign in1_ready = (state_q == GRANT1) && accept_ok;

    assign xfer0 = in0_valid && in0_ready;
    assign xfer1 = in1_valid && in1_ready;
    assign load  = xfer0 || xfer1;

    always_comb begin
        load_data = in0_data;
        load_last = in0_last;
        if (state_q == GRANT1) begin
            load_data = in1_data;
            load_last = in1_last;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                // in0 wins when alone or when it holds priority.
                if (in0_valid && (!in1_valid || !prio_q)) begin
                    state_d = GRANT0;
                    sel_d   = 1'b0;
                end else if (in1_valid) begin
                    state_d = GRANT1;
                    sel_d   = 1'b1;
                end
            end
            GRANT0: begin
                if (xfer0 && in0_last) begin
                    state_d = IDLE;
                    prio_d  = 1'b1;
                end
            end
            GRANT1: begin
                if (xfer1 && in1_last) begin
                    state_d = IDLE;
                    prio_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    out_reg_slice #(.W(W)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .accept_ok (accept_ok),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    assign sel  = sel_q;
    assign busy = (state_q != IDLE);

endmodule
